mdu: RTL and testbench

Parametrised iterative multiply/divide unit with HI/LO result registers, sitting beside the single-cycle ALU in the execute stage. It accepts one operation per start pulse and runs a W-iteration shift-add multiply or restoring divide. The result is written to HI/LO, with a busy/done handshake so the pipeline can stall MFHI/MFLO and later MDU ops. It also provides direct HI/LO writes (MTHI/MTLO) and an abort input for exception flush.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_step.sv | 35 +++
 rtl/mdu.sv | 127 ++++++++++++
 tb/tb_mdu.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and op-class helpers.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  function automatic logic op_is_iter(input logic [2:0] op);
    return op[2] == 1'b0;
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op == MDU_DIV || op == MDU_DIVU;
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return op == MDU_MULT || op == MDU_DIV;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: a shift-add multiply step or a restoring divide step.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] hi_w, lo_w;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             ge;

  assign hi_w = acc[2*WIDTH-1:WIDTH];
  assign lo_w = acc[WIDTH-1:0];

  // Multiply keeps {partial product, remaining multiplier bits}; carry shifts into the top.
  assign sum = {1'b0, hi_w} + (lo_w[0] ? {1'b0, m} : '0);

  // Divide keeps {remainder, dividend bits shifting into quotient bits}.
  assign shifted = {hi_w, lo_w[WIDTH-1]};
  assign ge      = shifted >= {1'b0, m};

  always_comb begin
    nxt = {sum, lo_w[WIDTH-1:1]};
    if (div) begin
      // A successful trial leaves remainder < m, so W-bit subtraction is exact.
      nxt = {ge ? (shifted[WIDTH-1:0] - m) : shifted[WIDTH-1:0],
             lo_w[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers, busy/done handshake and kill flush.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   m_q, a_q;
  logic               div_q, neg_res, neg_rem, dz_pend;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               sgn, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign busy   = state != S_IDLE;
  assign sgn    = op_is_signed(op);
  assign a_mag  = (sgn && A[WIDTH-1]) ? -A : A;
  assign b_mag  = (sgn && B[WIDTH-1]) ? -B : B;
  assign accept = state == S_IDLE && start && !kill;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div (div_q),
    .acc (acc),
    .m   (m_q),
    .nxt (acc_nxt)
  );

  // Final sign correction; divide-by-zero bypasses it and reports A / all-ones.
  always_comb begin
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
    if (div_q) begin
      if (dz_pend) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        if (neg_res) fix_lo = -acc[WIDTH-1:0];
        if (neg_rem) fix_hi = -acc[2*WIDTH-1:WIDTH];
      end
    end else if (neg_res) begin
      {fix_hi, fix_lo} = -acc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      m_q     <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz_pend <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      dz      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_is_iter(op)) begin
              acc     <= {{WIDTH{1'b0}}, a_mag};
              m_q     <= b_mag;
              a_q     <= A;
              div_q   <= op_is_div(op);
              neg_res <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_rem <= op == MDU_DIV && A[WIDTH-1];
              dz_pend <= op_is_div(op) && B == '0;
              cnt     <= CW'(WIDTH);
              state   <= S_RUN;
            end else if (op == MDU_MTHI || op == MDU_MTLO) begin
              if (op == MDU_MTHI) hi <= A;
              else                lo <= A;
              done <= 1'b1;
              dz   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (kill) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!kill) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            dz   <= div_q && dz_pend;
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu (WIDTH=32): results, done latency, dz, kill, ignored starts, MT ops, reset.
module tb_mdu;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk, rstn, start, kill;
  logic [2:0]   op;
  logic [W-1:0] A, B;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mdu #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .A(A), .B(B), .kill(kill),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Pulse start across E0; returns #1 into cycle 1.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Step cycles from c0 until done (bounded); reports done cycle and busy-cycle count.
  task automatic wait_done(input int c0, output int cyc, output int bcnt);
    cyc = c0; bcnt = 0;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input string tag);
    int cyc, bcnt;
    issue(o, a, b);
    wait_done(1, cyc, bcnt);
    chk({tag, "_cyc"}, 64'(cyc), 64'd34);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc, bcnt;
    logic seen;
    rstn = 1'b0; start = 1'b0; kill = 1'b0; op = '0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, cyc, bcnt);
    chk("multu_cyc", 64'(cyc), 64'd34);
    chk("multu_busy_cycles", 64'(bcnt), 64'd33);
    chk("multu_busy_at_done", 64'(busy), 64'd0);
    chk("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);

    run(MDU_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg");
    chk("mult_neg_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("mult_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFF1);

    run(MDU_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    chk("div_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    chk("div_neg_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);

    run(MDU_DIVU, 32'd7, 32'd2, "divu");
    chk("divu_lo", 64'(lo), 64'd3);
    chk("divu_hi", 64'(hi), 64'd1);
    chk("divu_dz", 64'(dz), 64'd0);

    run(MDU_DIVU, 32'd7, 32'd0, "divz");
    chk("divz_hi", 64'(hi), 64'd7);
    chk("divz_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    chk("divz_dz", 64'(dz), 64'd1);

    run(MDU_MULT, 32'd1, 32'd1, "mult_one");
    chk("mult_one_dz", 64'(dz), 64'd0);
    chk("mult_one_lo", 64'(lo), 64'd1);
    chk("mult_one_hi", 64'(hi), 64'd0);

    run(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'd0);
    chk("div_ovf_dz", 64'(dz), 64'd0);

    // Kill in cycle 10: no done, HI/LO keep 0 / 0x80000000.
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("kill_no_done", 64'(seen), 64'd0);
    chk("kill_hi", 64'(hi), 64'd0);
    chk("kill_lo", 64'(lo), 64'h0000_0000_8000_0000);

    // A start in cycle 5 of a run is dropped.
    issue(MDU_MULTU, 32'd3, 32'd4);
    repeat (4) begin @(posedge clk); #1; end
    op = MDU_DIVU; A = 32'd9; B = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6, cyc, bcnt);
    chk("ign_cyc", 64'(cyc), 64'd34);
    chk("ign_lo", 64'(lo), 64'd12);
    chk("ign_hi", 64'(hi), 64'd0);
    @(posedge clk); #1;
    chk("ign_no_second", 64'(busy), 64'd0);

    issue(MDU_MTHI, 32'h0000_1234, 32'd0);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_done", 64'(done), 64'd1);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_lo_kept", 64'(lo), 64'd12);

    issue(MDU_MTLO, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'h0000_0000_CAFE_F00D);
    chk("mtlo_done", 64'(done), 64'd1);

    issue(3'd6, 32'h5555_5555, 32'd1);
    chk("op6_busy", 64'(busy), 64'd0);
    chk("op6_done", 64'(done), 64'd0);
    chk("op6_hi", 64'(hi), 64'h1234);

    // Kill held with start in IDLE drops the start.
    kill = 1'b1;
    issue(MDU_MULTU, 32'd2, 32'd2);
    kill = 1'b0;
    chk("kill_idle_busy", 64'(busy), 64'd0);
    chk("kill_idle_done", 64'(done), 64'd0);

    // Asynchronous reset mid-RUN.
    issue(MDU_MULTU, 32'd5, 32'd5);
    repeat (9) begin @(posedge clk); #1; end
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    run(MDU_MULTU, 32'd2, 32'd3, "post_rst");
    chk("post_rst_lo", 64'(lo), 64'd6);
    chk("post_rst_hi", 64'(hi), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
